uart_loader: RTL and testbench

Downstream consumer of the UART receiver's byte stream. It turns a framed byte stream (word count, payload, optional checksum) into 32-bit memory write cycles for program/data memory. It raises `done` or `error` at the end of a load. It sits between the UART receive path and the memory write port used during boot loading.

---
 rtl/uart_loader_pkg.sv | 24 ++
 rtl/uart_loader_byte_assembler.sv | 63 ++++++
 rtl/uart_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encoding for the UART boot loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the SUM state and checksum compare).
package loader_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_W          = 32;
   localparam int LANE_W         = 2;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_HDR  = 3'd1;
   localparam state_t ST_DATA = 3'd2;
   localparam state_t ST_SUM  = 3'd3;
   localparam state_t ST_DONE = 3'd4;
   localparam state_t ST_ERR  = 3'd5;

   // States in which received bytes are consumed and start is ignored.
   function automatic logic is_busy(input state_t s);
      return (s == ST_HDR) || (s == ST_DATA) || (s == ST_SUM);
   endfunction

endpackage

// File: rtl/uart_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word is the current partial word with the incoming byte inserted; word_valid
// pulses in the cycle the 4th byte arrives so the consumer can register it.
module byte_assembler
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [WORD_W-1:0] shift_q, shift_d;

   // Insert the incoming byte into its lane and decide the next lane/partial word.
   always_comb begin
      word       = shift_q;
      word_valid = 1'b0;
      lane_d     = lane_q;
      shift_d    = shift_q;
      case (lane_q)
         2'd0:    word[7:0]   = byte_in;
         2'd1:    word[15:8]  = byte_in;
         2'd2:    word[23:16] = byte_in;
         2'd3:    word[31:24] = byte_in;
         default: word        = shift_q;
      endcase
      if (clear) begin
         lane_d  = '0;
         shift_d = '0;
      end else if (byte_valid) begin
         if (lane_q == LANE_LAST) begin
            word_valid = 1'b1;
            lane_d     = '0;
            shift_d    = '0;
         end else begin
            lane_d  = lane_q + 2'd1;
            shift_d = word;
         end
      end else begin
         lane_d  = lane_q;
         shift_d = shift_q;
      end
   end

   // Lane counter and partial-word register.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q  <= '0;
         shift_q <= '0;
      end else begin
         lane_q  <= lane_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: framed UART byte stream -> 32-bit memory write cycles.
// Frame: header N (words), N data words, then a checksum word when
// LOADER_CHECKSUM_EN is defined. All fields little-endian.
module uart_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int MAX_WORDS = 16384
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_byte,
   input  logic              rx_valid,
   input  logic              rx_timeout,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   target_q, target_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              busy_q, done_q, error_q;
`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q, sum_d;
`endif

   logic              start_acc_s;
   logic              asm_valid_s;
   logic [WORD_W-1:0] word_s;
   logic              word_valid_s;
   logic              hdr_ok_s;
   logic              last_word_s;

   // Only an idle/finished loader accepts start; bytes are only consumed while busy.
   assign start_acc_s = start && !is_busy(state_q);
   assign asm_valid_s = rx_valid && is_busy(state_q) && !rx_timeout;
   assign hdr_ok_s    = (word_s != 32'd0) && (word_s <= 32'(MAX_WORDS));
   assign last_word_s = ((count_q + CNT_ONE) == target_q);

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_acc_s | rx_timeout),
      .byte_valid (asm_valid_s),
      .byte_in    (rx_byte),
      .word       (word_s),
      .word_valid (word_valid_s)
   );

   // Load sequencing: header check, data writes, optional checksum compare.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      target_d    = target_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      if (start_acc_s) begin
         state_d = ST_HDR;
         count_d = '0;
`ifdef LOADER_CHECKSUM_EN
         sum_d   = '0;
`endif
      end else if (is_busy(state_q) && rx_timeout) begin
         state_d = ST_ERR;
      end else if (word_valid_s) begin
         case (state_q)
            ST_HDR: begin
               if (hdr_ok_s) begin
                  state_d  = ST_DATA;
                  target_d = word_s[ADDR_W:0];
               end else begin
                  state_d = ST_ERR;
               end
            end
            ST_DATA: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = count_q[ADDR_W-1:0];
               mem_wdata_d = word_s;
               count_d     = count_q + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
               sum_d       = sum_q + word_s;
               if (last_word_s) begin
                  state_d = ST_SUM;
               end else begin
                  state_d = ST_DATA;
               end
`else
               if (last_word_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DATA;
               end
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_SUM: begin
               if (word_s == sum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
               end
            end
`endif
            default: state_d = state_q;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         target_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         target_q    <= target_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= is_busy(state_d);
         done_q      <= (state_d == ST_DONE);
         error_q     <= (state_d == ST_ERR);
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader (default parameters).
// Checksum-specific scenarios are compiled when LOADER_CHECKSUM_EN is defined.
module tb_uart_loader;

   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_timeout = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              busy, done, error;
   logic [ADDR_W:0]   word_count;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int base   = 0;
   logic [ADDR_W-1:0] log_addr [64];
   logic [31:0]       log_data [64];

   uart_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .rx_timeout (rx_timeout),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Log every write strobe away from the active edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1 && we_cnt < 64) begin
         log_addr[we_cnt] = mem_addr;
         log_data[we_cnt] = mem_wdata;
         we_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         rx_byte  = w[8*i +: 8];
         rx_valid = 1'b1;
         tick();
      end
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic send_trailer(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
      send_word(s);
`else
      if (s == 32'hFFFF_FFFF) tick();
`endif
   endtask

   task automatic send_frame();
      send_word(32'd2);
      send_word(32'h1122_3344);
      send_word(32'hDEAD_BEEF);
      send_trailer(32'hEFCF_F233);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
      checks++; if (word_count !== '0) begin errors++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
   endtask

   task automatic test_load();
      do_reset();
      base = we_cnt;
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_rise: got %b want 1", busy); end
      send_word(32'd2);
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_hdr_no_we: got %b want 0", mem_we); end
      send_word(32'h1122_3344);
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL load_w0_we: got %b want 1", mem_we); end
      checks++; if (mem_addr !== 14'd0) begin errors++; $display("FAIL load_w0_addr: got %0d want 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h1122_3344) begin errors++; $display("FAIL load_w0_data: got %h want 11223344", mem_wdata); end
      checks++; if (word_count !== 15'd1) begin errors++; $display("FAIL load_w0_count: got %0d want 1", word_count); end
      send_word(32'hDEAD_BEEF);
      checks++; if (mem_addr !== 14'd1) begin errors++; $display("FAIL load_w1_addr: got %0d want 1", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_w1_data: got %h want deadbeef", mem_wdata); end
`ifdef LOADER_CHECKSUM_EN
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_sum_pending: got done=%b want 0", done); end
      send_word(32'hEFCF_F233);
`endif
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done: got %b want 1", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL load_error: got %b want 0", error); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_fall: got %b want 0", busy); end
      checks++; if (word_count !== 15'd2) begin errors++; $display("FAIL load_count: got %0d want 2", word_count); end
      tick();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_we_one_cycle: got %b want 0", mem_we); end
      send_word(32'h5555_5555);
      tick();
      checks++; if (we_cnt - base !== 2) begin errors++; $display("FAIL load_write_count: got %0d want 2", we_cnt - base); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done_holds: got %b want 1", done); end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      base = we_cnt;
      pulse_start();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL badsum_done_clear: got %b want 0", done); end
      send_word(32'd2);
      send_word(32'h1122_3344);
      send_word(32'hDEAD_BEEF);
      send_word(32'hEFCF_F234);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL badsum_error: got %b want 1", error); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL badsum_done: got %b want 0", done); end
      tick();
      checks++; if (we_cnt - base !== 2) begin errors++; $display("FAIL badsum_writes: got %0d want 2", we_cnt - base); end
   endtask
`endif

   task automatic test_header_bounds();
      base = we_cnt;
      pulse_start();
      send_word(32'd0);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL hdr_zero_error: got %b want 1", error); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hdr_zero_busy: got %b want 0", busy); end
      pulse_start();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL hdr_start_clears_error: got %b want 0", error); end
      send_word(32'd16385);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL hdr_over_max_error: got %b want 1", error); end
      pulse_start();
      send_word(32'd16384);
      checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL hdr_max_accept: got busy=%b error=%b want 1 0", busy, error); end
      rx_timeout = 1'b1;
      tick();
      rx_timeout = 1'b0;
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL hdr_max_timeout: got %b want 1", error); end
      tick();
      checks++; if (we_cnt - base !== 0) begin errors++; $display("FAIL hdr_no_writes: got %0d want 0", we_cnt - base); end
   endtask

   task automatic test_timeout();
      base = we_cnt;
      pulse_start();
      send_word(32'd2);
      send_byte(8'h44);
      send_byte(8'h33);
      rx_timeout = 1'b1;
      tick();
      rx_timeout = 1'b0;
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b want 1", error); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
      checks++; if (word_count !== 15'd0) begin errors++; $display("FAIL tmo_count: got %0d want 0", word_count); end
      send_byte(8'h22);
      send_byte(8'h11);
      tick();
      checks++; if (we_cnt - base !== 0) begin errors++; $display("FAIL tmo_no_writes: got %0d want 0", we_cnt - base); end
   endtask

   task automatic test_reset_mid();
      pulse_start();
      send_word(32'd2);
      send_byte(8'h99);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b we=%b want 0 0", busy, mem_we); end
      checks++; if (word_count !== 15'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", word_count); end
      base = we_cnt;
      pulse_start();
      send_byte(8'h02);
      tick();
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_word(32'h1122_3344);
      send_word(32'hDEAD_BEEF);
      send_trailer(32'hEFCF_F233);
      tick();
      checks++; if (we_cnt - base !== 2) begin errors++; $display("FAIL rstmid_writes: got %0d want 2", we_cnt - base); end
      checks++; if (log_addr[base] !== 14'd0 || log_data[base] !== 32'h1122_3344) begin errors++; $display("FAIL rstmid_first_write: got %0d:%h want 0:11223344", log_addr[base], log_data[base]); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b want 1", done); end
   endtask

   task automatic test_ignored_bytes();
      do_reset();
      send_byte(8'h55);
      send_byte(8'h66);
      checks++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy=%b we=%b want 0 0", busy, mem_we); end
      base = we_cnt;
      start    = 1'b1;
      rx_byte  = 8'h02;
      rx_valid = 1'b1;
      tick();
      start    = 1'b0;
      rx_valid = 1'b0;
      send_frame();
      checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL ign_done: got done=%b error=%b want 1 0", done, error); end
      tick();
      checks++; if (we_cnt - base !== 2) begin errors++; $display("FAIL ign_writes: got %0d want 2", we_cnt - base); end
      checks++; if (log_data[base+1] !== 32'hDEAD_BEEF || log_addr[base+1] !== 14'd1) begin errors++; $display("FAIL ign_second_write: got %0d:%h want 1:deadbeef", log_addr[base+1], log_data[base+1]); end
   endtask

   task automatic test_start_while_busy();
      pulse_start();
      send_word(32'd1);
      send_byte(8'h78);
      pulse_start();
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL busy_start_word: got we=%b data=%h want 1 12345678", mem_we, mem_wdata); end
      checks++; if (mem_addr !== 14'd0) begin errors++; $display("FAIL busy_start_addr: got %0d want 0", mem_addr); end
      send_trailer(32'h1234_5678);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done: got %b want 1", done); end
   endtask

   initial begin
      test_reset();
      test_load();
`ifdef LOADER_CHECKSUM_EN
      test_bad_checksum();
`endif
      test_header_bounds();
      test_timeout();
      test_reset_mid();
      test_ignored_bytes();
      test_start_while_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
